// File: rtl/mem_port_arbiter_if.sv
// Memory-port arbiter bus bundle.
// Carries both requester channels (req/we/addr/wdata in, gnt/rvalid/rdata out)
// and the shared synchronous-read memory port (mem_en/we/addr/wdata out, mem_rdata in).
//   slave  : arbiter side
//   master : requester + memory side (testbench / surrounding system)
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single synchronous-read data-memory port.
// Requester 0 is the processor load/store path, requester 1 the program/debug loader.
// Under contention a requester may hold the port for at most BURST_MAX consecutive
// grants. Grants and the memory drive are combinational; read responses are routed
// back to their requester one cycle after the grant.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_port_arbiter_if.slave (requester channels + memory port)
module mem_port_arbiter #(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mem_port_arbiter_if.slave       bus
);
    localparam int unsigned CW = $clog2(BURST_MAX + 1);

    logic          last_gnt_q, last_gnt_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;

    logic          gnt0_c;
    logic          gnt1_c;
    logic          winner_c;
    logic          mem_en_c;
    logic          mem_we_c;
    logic [AW-1:0] mem_addr_c;
    logic [DW-1:0] mem_wdata_c;

    // Arbitration: burst_cnt==0 means the previous cycle had no grant, so the
    // non-last requester wins; a full burst also hands the port over.
    always_comb begin
        gnt0_c   = 1'b0;
        gnt1_c   = 1'b0;
        winner_c = 1'b0;
        if (bus.req0 && !bus.req1) begin
            gnt0_c = 1'b1;
        end else if (bus.req1 && !bus.req0) begin
            gnt1_c = 1'b1;
        end else if (bus.req0 && bus.req1) begin
            if (burst_cnt_q == '0 || burst_cnt_q >= CW'(BURST_MAX)) begin
                winner_c = ~last_gnt_q;
            end else begin
                winner_c = last_gnt_q;
            end
            gnt0_c = ~winner_c;
            gnt1_c = winner_c;
        end
    end

    // Memory drive, zeroed when nobody holds the port.
    always_comb begin
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        if (gnt0_c) begin
            mem_en_c    = 1'b1;
            mem_we_c    = bus.we0;
            mem_addr_c  = bus.addr0;
            mem_wdata_c = bus.wdata0;
        end else if (gnt1_c) begin
            mem_en_c    = 1'b1;
            mem_we_c    = bus.we1;
            mem_addr_c  = bus.addr1;
            mem_wdata_c = bus.wdata1;
        end
    end

    // Next-state: burst bookkeeping and read-response ownership.
    always_comb begin
        last_gnt_d  = last_gnt_q;
        burst_cnt_d = burst_cnt_q;
        rvalid0_d   = gnt0_c && !bus.we0;
        rvalid1_d   = gnt1_c && !bus.we1;
        if (gnt0_c || gnt1_c) begin
            if (gnt1_c == last_gnt_q) begin
                if (burst_cnt_q < CW'(BURST_MAX)) begin
                    burst_cnt_d = burst_cnt_q + CW'(1);
                end
            end else begin
                burst_cnt_d = CW'(1);
                last_gnt_d  = gnt1_c;
            end
        end else begin
            burst_cnt_d = '0;
        end
    end

    // State registers; reset biases the first contention toward requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q  <= 1'b1;
            burst_cnt_q <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
        end else begin
            last_gnt_q  <= last_gnt_d;
            burst_cnt_q <= burst_cnt_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
        end
    end

    assign bus.gnt0      = gnt0_c;
    assign bus.gnt1      = gnt1_c;
    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.rvalid0   = rvalid0_q;
    assign bus.rvalid1   = rvalid1_q;
    // Read data is only passed through to the owner of the pending response.
    assign bus.rdata0    = rvalid0_q ? bus.mem_rdata : '0;
    assign bus.rdata1    = rvalid1_q ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with BURST_MAX=4 backed by a
// small synchronous-read memory model, one with BURST_MAX=1 for alternation.
module tb_mem_port_arbiter;
    logic clk;
    logic rst_n;
    logic preload;

    mem_port_arbiter_if #(.AW(32), .DW(32)) busa ();
    mem_port_arbiter_if #(.AW(32), .DW(32)) busb ();

    mem_port_arbiter #(.AW(32), .DW(32), .BURST_MAX(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(busa)
    );
    mem_port_arbiter #(.AW(32), .DW(32), .BURST_MAX(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(busb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory model, word-indexed by addr[9:2].
    logic [31:0] mem [0:255];
    logic [31:0] mrd_q;
    always @(posedge clk) begin
        if (preload) begin
            mem[8]  <= 32'h1234_5678;
            mem[64] <= 32'hA0A0_A0A0;
            mem[65] <= 32'hB1B1_B1B1;
        end else if (busa.mem_en) begin
            if (busa.mem_we) mem[busa.mem_addr[9:2]] <= busa.mem_wdata;
            else             mrd_q <= mem[busa.mem_addr[9:2]];
        end
    end
    assign busa.mem_rdata = mrd_q;
    assign busb.mem_rdata = '0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive_a(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                           input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        busa.req0 = r0; busa.we0 = w0; busa.addr0 = a0; busa.wdata0 = d0;
        busa.req1 = r1; busa.we1 = w1; busa.addr1 = a1; busa.wdata1 = d1;
    endtask

    // Advance to 1 time unit after the rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic r0, r1;
        logic g0, g1;
        logic v0, v1;
    } vec_t;
    vec_t vecs [11];

    initial begin
        // Contention table: BURST_MAX=4 out of reset, both reading.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_n   = 1'b0;
        preload = 1'b1;
        drive_a(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        busb.req0 = 1'b0; busb.we0 = 1'b0; busb.addr0 = '0; busb.wdata0 = '0;
        busb.req1 = 1'b0; busb.we1 = 1'b0; busb.addr1 = '0; busb.wdata1 = '0;
        tick();
        tick();
        preload = 1'b0;
        rst_n   = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            chk("idle_gnt_en_rv", 64'({busa.gnt0, busa.gnt1, busa.mem_en, busa.rvalid0, busa.rvalid1}), 64'd0);
        end
        chk("idle_mem_bus", 64'({busa.mem_we, busa.mem_addr, busa.mem_wdata[30:0]}), 64'd0);

        // Requester 1 write then read back.
        tick();
        drive_a(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        #1;
        chk("wr1_gnt", 64'({busa.gnt0, busa.gnt1, busa.mem_en, busa.mem_we}), 64'b0111);
        chk("wr1_addr", 64'(busa.mem_addr), 64'h10);
        chk("wr1_wdata", 64'(busa.mem_wdata), 64'hDEAD_BEEF);
        tick();
        drive_a(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        chk("rd1_gnt", 64'({busa.gnt0, busa.gnt1, busa.mem_en, busa.mem_we, busa.rvalid1}), 64'b01100);
        tick();
        drive_a(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("rd1_rvalid", 64'({busa.rvalid0, busa.rvalid1}), 64'b01);
        chk("rd1_rdata1", 64'(busa.rdata1), 64'hDEAD_BEEF);
        chk("rd1_rdata0", 64'(busa.rdata0), 64'h0);
        tick();
        #1;
        chk("rd1_rvalid_drop", 64'({busa.rvalid0, busa.rvalid1}), 64'b00);

        // Fresh reset, then table-driven contention.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            drive_a(vecs[i].r0, 1'b0, 32'h100, 32'h0, vecs[i].r1, 1'b0, 32'h104, 32'h0);
            #1;
            chk($sformatf("cont_gnt[%0d]", i), 64'({busa.gnt0, busa.gnt1}), 64'({vecs[i].g0, vecs[i].g1}));
            chk($sformatf("cont_rv[%0d]", i), 64'({busa.rvalid0, busa.rvalid1}), 64'({vecs[i].v0, vecs[i].v1}));
            chk($sformatf("cont_rd0[%0d]", i), 64'(busa.rdata0), vecs[i].v0 ? 64'hA0A0_A0A0 : 64'h0);
            chk($sformatf("cont_rd1[%0d]", i), 64'(busa.rdata1), vecs[i].v1 ? 64'hB1B1_B1B1 : 64'h0);
        end

        // req0 continuous; req1 pulsed once while requester 0 is mid-burst.
        for (int i = 0; i < 4; i++) begin
            tick();
            drive_a(1'b1, 1'b0, 32'h100, 32'h0, (i == 1), 1'b0, 32'h104, 32'h0);
            #1;
            chk($sformatf("pulse_gnt[%0d]", i), 64'({busa.gnt0, busa.gnt1}), 64'b10);
            chk($sformatf("pulse_addr[%0d]", i), 64'(busa.mem_addr), 64'h100);
            chk($sformatf("pulse_rv1[%0d]", i), 64'(busa.rvalid1), 64'd0);
        end
        tick();
        drive_a(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Reset during the rvalid cycle of a requester 0 read.
        tick();
        drive_a(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("rst_rd_gnt", 64'({busa.gnt0, busa.gnt1}), 64'b10);
        tick();
        drive_a(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("rst_rv_pre", 64'(busa.rvalid0), 64'd1);
        chk("rst_rdata_pre", 64'(busa.rdata0), 64'h1234_5678);
        rst_n = 1'b0;
        #1;
        chk("rst_rv_cleared", 64'({busa.rvalid0, busa.rvalid1}), 64'b00);
        chk("rst_rdata_cleared", 64'(busa.rdata0), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        drive_a(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h104, 32'h0);
        #1;
        chk("rst_first_contention", 64'({busa.gnt0, busa.gnt1}), 64'b10);
        tick();
        drive_a(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // BURST_MAX=1: strict alternation.
        for (int i = 0; i < 4; i++) begin
            tick();
            busb.req0 = 1'b1;
            busb.req1 = 1'b1;
            #1;
            chk($sformatf("alt_gnt[%0d]", i), 64'({busb.gnt0, busb.gnt1}), (i % 2 == 0) ? 64'b10 : 64'b01);
        end
        tick();
        busb.req0 = 1'b0;
        busb.req1 = 1'b0;
        #1;
        chk("alt_idle", 64'({busb.gnt0, busb.gnt1, busb.mem_en}), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
